// File: rtl/rs485_tx_arbiter.sv
// ============================================================================
//  Module   : rs485_tx_arbiter
//  Purpose  : Frame-locked round-robin sharing of one RS-485 byte transmitter
//             between two requesters, with bus-turnaround hold-off.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs485_tx_arbiter #(
    parameter int RX_HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES     = 64,
    parameter int STALL_CYCLES   = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       rx_ready,
    input  logic       tx_ready,
    output logic       tx_cmd,
    output logic [7:0] tx_data,
    output logic       r2tdelay_en,
    output logic [1:0] grant,
    output logic       busy,
    output logic       stall_err
);

    localparam logic [2:0]  c_IDLE      = 3'd0;
    localparam logic [2:0]  c_ISSUE     = 3'd1;
    localparam logic [2:0]  c_WAIT_LOW  = 3'd2;
    localparam logic [2:0]  c_WAIT_HIGH = 3'd3;
    localparam logic [2:0]  c_GAP       = 3'd4;

    localparam logic [15:0] c_rx_hold   = 16'(RX_HOLD_CYCLES);
    localparam logic [15:0] c_stall_max = 16'(STALL_CYCLES - 1);
    localparam logic [16:0] c_gap       = 17'(GAP_CYCLES);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_quiet_cnt;
    logic        r_rx_seen;
    logic [1:0]  r_grant;
    logic        r_last_owner;
    logic        r_tx_cmd;
    logic [7:0]  r_tx_data;
    logic        r_r2t;
    logic        r_stall_err;
    logic        r_first;
    logic        r_frame_last;
    logic [15:0] r_stall_cnt;
    logic [2:0]  r_wl_cnt;
    logic        r_restrobed;
    logic [15:0] r_gap_cnt;

    logic        w_bus_quiet;
    logic        w_sel_valid;
    logic [7:0]  w_sel_data;
    logic        w_sel_last;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic        w_stall_hit;
    logic        w_grant_ok;
    logic        w_pick1;
    logic        w_restrobe;
    logic        w_gap_done;
    logic        w_frame_done;

    assign w_bus_quiet = (r_quiet_cnt == 16'd0) && !rx_ready;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = 8'd0;
        w_sel_last  = 1'b0;
        if (r_grant[0]) begin
            w_sel_valid = req0_valid;
            w_sel_data  = req0_data;
            w_sel_last  = req0_last;
        end else if (r_grant[1]) begin
            w_sel_valid = req1_valid;
            w_sel_data  = req1_data;
            w_sel_last  = req1_last;
        end
    end

    assign w_ready0    = (r_state == c_ISSUE) && r_grant[0] && tx_ready;
    assign w_ready1    = (r_state == c_ISSUE) && r_grant[1] && tx_ready;
    assign w_accept    = (w_ready0 && req0_valid) || (w_ready1 && req1_valid);
    assign w_stall_hit = (r_state == c_ISSUE) && !w_sel_valid && (r_stall_cnt == c_stall_max);
    assign w_grant_ok  = (r_state == c_IDLE) && w_bus_quiet && tx_ready && (req0_valid || req1_valid);
    // Contended grant goes to whoever did not own the bus last.
    assign w_pick1     = req1_valid && (!req0_valid || !r_last_owner);
    assign w_restrobe  = (r_state == c_WAIT_LOW) && tx_ready && !r_restrobed && (r_wl_cnt == 3'd7);
    assign w_gap_done  = ({1'b0, r_gap_cnt} + 17'd1) >= c_gap;
    assign w_frame_done = (r_state == c_WAIT_HIGH) && tx_ready && r_frame_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_ok) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_accept) begin
                    w_state_nxt = c_WAIT_LOW;
                end else if (w_stall_hit) begin
                    w_state_nxt = c_GAP;
                end
            end
            c_WAIT_LOW: begin
                if (!tx_ready) begin
                    w_state_nxt = c_WAIT_HIGH;
                end
            end
            c_WAIT_HIGH: begin
                if (tx_ready) begin
                    w_state_nxt = r_frame_last ? c_GAP : c_ISSUE;
                end
            end
            c_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_quiet_cnt  <= 16'd0;
            r_rx_seen    <= 1'b0;
            r_grant      <= 2'b00;
            r_last_owner <= 1'b1;
            r_tx_cmd     <= 1'b0;
            r_tx_data    <= 8'd0;
            r_r2t        <= 1'b0;
            r_stall_err  <= 1'b0;
            r_first      <= 1'b0;
            r_frame_last <= 1'b0;
            r_stall_cnt  <= 16'd0;
            r_wl_cnt     <= 3'd0;
            r_restrobed  <= 1'b0;
            r_gap_cnt    <= 16'd0;
        end else begin
            if (rx_ready) begin
                r_quiet_cnt <= c_rx_hold;
            end else if (r_quiet_cnt != 16'd0) begin
                r_quiet_cnt <= r_quiet_cnt - 16'd1;
            end

            // A fresh reception outranks the clear from the byte being issued now.
            if (rx_ready) begin
                r_rx_seen <= 1'b1;
            end else if (w_accept && r_first && r_rx_seen) begin
                r_rx_seen <= 1'b0;
            end

            r_tx_cmd    <= w_accept || w_restrobe;
            r_stall_err <= w_stall_hit;

            if (w_accept) begin
                r_tx_data    <= w_sel_data;
                r_r2t        <= r_first && r_rx_seen;
                r_first      <= 1'b0;
                r_frame_last <= w_sel_last;
            end

            if (w_grant_ok) begin
                r_grant      <= w_pick1 ? 2'b10 : 2'b01;
                r_last_owner <= w_pick1;
                r_first      <= 1'b1;
            end else if (w_stall_hit || w_frame_done) begin
                r_grant <= 2'b00;
            end

            if ((r_state != c_ISSUE) || w_accept || w_sel_valid) begin
                r_stall_cnt <= 16'd0;
            end else begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end

            // Counts clocks since the strobe that the transmitter has not gone busy.
            if (r_state != c_WAIT_LOW) begin
                r_wl_cnt <= 3'd0;
            end else if (tx_ready && (r_wl_cnt != 3'd7)) begin
                r_wl_cnt <= r_wl_cnt + 3'd1;
            end

            if (w_accept) begin
                r_restrobed <= 1'b0;
            end else if (w_restrobe) begin
                r_restrobed <= 1'b1;
            end

            if (r_state != c_GAP) begin
                r_gap_cnt <= 16'd0;
            end else begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end
        end
    end

    assign req0_ready  = w_ready0;
    assign req1_ready  = w_ready1;
    assign tx_cmd      = r_tx_cmd;
    assign tx_data     = r_tx_data;
    assign r2tdelay_en = r_r2t;
    assign grant       = r_grant;
    assign busy        = (r_state != c_IDLE);
    assign stall_err   = r_stall_err;

endmodule

`default_nettype wire

// File: tb/tb_rs485_tx_arbiter.sv
// ============================================================================
//  Module   : tb_rs485_tx_arbiter
//  Purpose  : Directed self-checking bench for rs485_tx_arbiter with a small
//             transmitter model (busy for five clocks per strobe).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rs485_tx_arbiter;

    localparam int c_RX_HOLD = 20;
    localparam int c_GAP     = 4;
    localparam int c_STALL   = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       rq_valid [2];
    logic [7:0] rq_data  [2];
    logic       rq_last  [2];
    logic       req0_ready, req1_ready;
    logic       rx_ready;
    logic       tx_ready;
    logic       tx_cmd;
    logic [7:0] tx_data;
    logic       r2tdelay_en;
    logic [1:0] grant;
    logic       busy;
    logic       stall_err;

    logic       stuck;
    logic       hold_low;
    int         bcnt;
    int         cyc;
    int         n_chk;
    int         n_err;

    logic [7:0] m_data  [$];
    logic       m_r2t   [$];
    logic [1:0] m_grant [$];
    int         m_cyc   [$];
    int         n_stall;
    int         stall_cyc;
    logic [1:0] stall_grant;
    int         n_dual;
    int         n_gapcyc;

    rs485_tx_arbiter #(
        .RX_HOLD_CYCLES (c_RX_HOLD),
        .GAP_CYCLES     (c_GAP),
        .STALL_CYCLES   (c_STALL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (rq_valid[0]),
        .req0_data   (rq_data[0]),
        .req0_last   (rq_last[0]),
        .req0_ready  (req0_ready),
        .req1_valid  (rq_valid[1]),
        .req1_data   (rq_data[1]),
        .req1_last   (rq_last[1]),
        .req1_ready  (req1_ready),
        .rx_ready    (rx_ready),
        .tx_ready    (tx_ready),
        .tx_cmd      (tx_cmd),
        .tx_data     (tx_data),
        .r2tdelay_en (r2tdelay_en),
        .grant       (grant),
        .busy        (busy),
        .stall_err   (stall_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter model: goes busy for five clocks after each strobe.
    always begin
        @(posedge clock);
        #1;
        if (reset) begin
            tx_ready = 1'b1;
            bcnt     = 0;
        end else if (hold_low) begin
            tx_ready = 1'b0;
        end else if (tx_cmd && !stuck) begin
            tx_ready = 1'b0;
            bcnt     = 5;
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) tx_ready = 1'b1;
        end else begin
            tx_ready = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (tx_cmd) begin
            m_data.push_back(tx_data);
            m_r2t.push_back(r2tdelay_en);
            m_grant.push_back(grant);
            m_cyc.push_back(cyc);
        end
        if (stall_err) begin
            n_stall     = n_stall + 1;
            stall_cyc   = cyc;
            stall_grant = grant;
        end
        if (grant == 2'b11) n_dual = n_dual + 1;
        if (busy && grant == 2'b00) n_gapcyc = n_gapcyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        rq_valid[0] = 1'b0;
        rq_valid[1] = 1'b0;
        rx_ready    = 1'b0;
        stuck       = 1'b0;
        hold_low    = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic send_byte(input int id, input logic [7:0] d, input logic l);
        logic got;
        got          = 1'b0;
        rq_valid[id] = 1'b1;
        rq_data[id]  = d;
        rq_last[id]  = l;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clock);
            if ((id == 0) ? req0_ready : req1_ready) got = 1'b1;
        end
        if (!got) check_eq($sformatf("send%0d_timeout", id), 32'(got), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clock);
            if (!busy) done = 1'b1;
        end
        if (!done) check_eq("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_tx_cmd"},    32'(tx_cmd),      32'd0);
        check_eq({pfx, "_tx_data"},   32'(tx_data),     32'd0);
        check_eq({pfx, "_r2t"},       32'(r2tdelay_en), 32'd0);
        check_eq({pfx, "_grant"},     32'(grant),       32'd0);
        check_eq({pfx, "_busy"},      32'(busy),        32'd0);
        check_eq({pfx, "_stall_err"}, 32'(stall_err),   32'd0);
    endtask

    initial begin
        int         base;
        int         g0;
        int         s0;
        int         c0;
        logic [7:0] exp_d [4];
        logic [1:0] exp_g [4];

        n_chk       = 0;
        n_err       = 0;
        n_stall     = 0;
        n_dual      = 0;
        n_gapcyc    = 0;
        stall_cyc   = 0;
        stall_grant = 2'b00;
        rq_data[0]  = 8'd0;
        rq_data[1]  = 8'd0;
        rq_last[0]  = 1'b0;
        rq_last[1]  = 1'b0;

        // Reset values
        do_reset();
        @(negedge clock);
        check_reset_outputs("rst");

        // Three-byte frame from requester 0, no reception
        base = m_data.size();
        g0   = n_gapcyc;
        send_byte(0, 8'hA1, 1'b0);
        send_byte(0, 8'hA2, 1'b0);
        send_byte(0, 8'hA3, 1'b1);
        rq_valid[0] = 1'b0;
        wait_idle();
        check_eq("t1_count", 32'(m_data.size() - base), 32'd3);
        exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            if (base + i < m_data.size()) begin
                check_eq($sformatf("t1_data%0d", i),  32'(m_data[base+i]),  32'(exp_d[i]));
                check_eq($sformatf("t1_r2t%0d", i),   32'(m_r2t[base+i]),   32'd0);
                check_eq($sformatf("t1_grant%0d", i), 32'(m_grant[base+i]), 32'd1);
            end
        end
        check_eq("t1_gap_cycles", 32'(n_gapcyc - g0), 32'(c_GAP));

        // Both requesters contend, two one-byte frames each
        do_reset();
        base = m_data.size();
        s0   = n_dual;
        fork
            begin
                send_byte(0, 8'h01, 1'b1);
                send_byte(0, 8'h02, 1'b1);
                rq_valid[0] = 1'b0;
            end
            begin
                send_byte(1, 8'h81, 1'b1);
                send_byte(1, 8'h82, 1'b1);
                rq_valid[1] = 1'b0;
            end
        join
        wait_idle();
        check_eq("t2_count", 32'(m_data.size() - base), 32'd4);
        exp_d[0] = 8'h01; exp_d[1] = 8'h81; exp_d[2] = 8'h02; exp_d[3] = 8'h82;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (base + i < m_data.size()) begin
                check_eq($sformatf("t2_data%0d", i),  32'(m_data[base+i]),  32'(exp_d[i]));
                check_eq($sformatf("t2_grant%0d", i), 32'(m_grant[base+i]), 32'(exp_g[i]));
            end
        end
        check_eq("t2_dual_grant", 32'(n_dual - s0), 32'd0);

        // Reception holds off the grant, first byte takes turnaround delay
        do_reset();
        base = m_data.size();
        @(posedge clock);
        #1;
        rx_ready = 1'b1;
        @(negedge clock);
        c0 = cyc;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
        send_byte(1, 8'h55, 1'b0);
        send_byte(1, 8'h66, 1'b1);
        rq_valid[1] = 1'b0;
        wait_idle();
        check_eq("t3_count", 32'(m_data.size() - base), 32'd2);
        if (m_data.size() >= base + 2) begin
            check_eq("t3_holdoff", 32'(m_cyc[base] - c0), 32'(c_RX_HOLD + 3));
            check_eq("t3_data0", 32'(m_data[base]),    32'h55);
            check_eq("t3_r2t0",  32'(m_r2t[base]),     32'd1);
            check_eq("t3_data1", 32'(m_data[base+1]),  32'h66);
            check_eq("t3_r2t1",  32'(m_r2t[base+1]),   32'd0);
        end

        // Mid-frame stall aborts the frame, the other requester follows
        do_reset();
        base = m_data.size();
        s0   = n_stall;
        fork
            begin
                send_byte(0, 8'h10, 1'b0);
                rq_valid[0] = 1'b0;
            end
            begin
                send_byte(1, 8'h77, 1'b1);
                rq_valid[1] = 1'b0;
            end
        join
        wait_idle();
        check_eq("t4_stall_pulses", 32'(n_stall - s0), 32'd1);
        check_eq("t4_stall_grant",  32'(stall_grant),  32'd0);
        check_eq("t4_count", 32'(m_data.size() - base), 32'd2);
        if (m_data.size() >= base + 2) begin
            check_eq("t4_stall_time", 32'(stall_cyc - m_cyc[base]), 32'(c_STALL + 6));
            check_eq("t4_data0",  32'(m_data[base]),    32'h10);
            check_eq("t4_grant0", 32'(m_grant[base]),   32'd1);
            check_eq("t4_data1",  32'(m_data[base+1]),  32'h77);
            check_eq("t4_grant1", 32'(m_grant[base+1]), 32'd2);
        end

        // Reset while the transmitter is busy abandons the frame
        do_reset();
        base = m_data.size();
        send_byte(0, 8'h33, 1'b0);
        rq_valid[0] = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check_eq("t5_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("t5");
        @(posedge clock);
        #2;
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check_eq("t5_no_more_tx", 32'(m_data.size() - base), 32'd1);

        // Transmitter stuck idle: exactly one re-strobe eight clocks later
        do_reset();
        stuck = 1'b1;
        base  = m_data.size();
        send_byte(0, 8'h5A, 1'b1);
        rq_valid[0] = 1'b0;
        repeat (20) @(negedge clock);
        check_eq("t6_count", 32'(m_data.size() - base), 32'd2);
        if (m_data.size() >= base + 2) begin
            check_eq("t6_delay", 32'(m_cyc[base+1] - m_cyc[base]), 32'd8);
            check_eq("t6_data0", 32'(m_data[base]),   32'h5A);
            check_eq("t6_data1", 32'(m_data[base+1]), 32'h5A);
        end
        stuck    = 1'b0;
        hold_low = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        hold_low = 1'b0;
        wait_idle();
        check_eq("t6_final_count", 32'(m_data.size() - base), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
